// File: rtl/alu_seq_pkg.sv
// Shared command codes and FSM state type for the ALU sequencer.
package alu_seq_pkg;

  localparam logic [3:0] CMD_ADD = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0101;
  localparam logic [3:0] CMD_MUL = 4'b1000;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StMul,
    StDone
  } state_e;

endpackage

// File: rtl/alu_seq_booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/subtract of the
// multiplicand into the accumulator, then arithmetic shift right of {acc, mq, q-1}.
module alu_seq_booth_step
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W:0]   acc,
  input  logic [DATA_W-1:0] mcand,
  input  logic [DATA_W-1:0] mq,
  input  logic              qm1,
  output logic [DATA_W:0]   acc_next,
  output logic [DATA_W-1:0] mq_next,
  output logic              qm1_next
);

  // Accumulator is one bit wider than the operands so that subtracting the
  // most negative multiplicand cannot overflow.
  logic [DATA_W:0] mcand_x;
  logic [DATA_W:0] sum;

  // Booth recoding on {mq[0], q-1} followed by the arithmetic shift.
  always_comb begin
    mcand_x = {mcand[DATA_W-1], mcand};
    case ({mq[0], qm1})
      2'b01:   sum = acc + mcand_x;
      2'b10:   sum = acc - mcand_x;
      default: sum = acc;
    endcase
    acc_next = {sum[DATA_W], sum[DATA_W:1]};
    mq_next  = {sum[0], mq[DATA_W-1:1]};
    qm1_next = mq[0];
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequenced ALU: single-cycle add/sub, 16-step Booth multiply, with a
// valid/ready handshake on both the request and the result side.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     inputA,
  input  logic [DATA_W-1:0]     inputB,
  input  logic [3:0]            command,
  input  logic                  start_valid,
  output logic                  start_ready,
  output logic [2*DATA_W-1:0]   result,
  output logic                  error,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastStep = CntW'(DATA_W - 1);

  state_e state_q, state_d;

  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [DATA_W:0]     acc_q, acc_d;
  logic [DATA_W-1:0]   mq_q, mq_d;
  logic                qm1_q, qm1_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                error_q, error_d;

  logic [DATA_W:0]     acc_step;
  logic [DATA_W-1:0]   mq_step;
  logic                qm1_step;

  logic                is_sub;
  logic [DATA_W-1:0]   b_eff;
  logic [DATA_W-1:0]   sum;
  logic                ovf;

  alu_seq_booth_step #(
    .DATA_W (DATA_W)
  ) u_booth_step (
    .acc      (acc_q),
    .mcand    (a_q),
    .mq       (mq_q),
    .qm1      (qm1_q),
    .acc_next (acc_step),
    .mq_next  (mq_step),
    .qm1_next (qm1_step)
  );

  // Shared adder for ADD/SUB; SUB is A + ~B + 1 so overflow uses the inverted B sign.
  always_comb begin
    is_sub = (cmd_q == CMD_SUB);
    b_eff  = is_sub ? ~b_q : b_q;
    sum    = a_q + b_eff + {{(DATA_W-1){1'b0}}, is_sub};
    ovf    = (a_q[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
  end

  // Next-state and datapath updates; result/error only change on entry to DONE.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cmd_d    = cmd_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    error_d  = error_q;

    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          a_d     = inputA;
          b_d     = inputB;
          cmd_d   = command;
          acc_d   = '0;
          mq_d    = inputB;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = (command == CMD_MUL) ? StMul : StExec;
        end
      end
      StExec: begin
        state_d = StDone;
        if (cmd_q == CMD_ADD || cmd_q == CMD_SUB) begin
          result_d = {{DATA_W{sum[DATA_W-1]}}, sum};
          error_d  = ovf;
        end else begin
          result_d = '0;
          error_d  = 1'b1;
        end
      end
      StMul: begin
        acc_d = acc_step;
        mq_d  = mq_step;
        qm1_d = qm1_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastStep) begin
          // Low DATA_W bits of the wide accumulator plus mq form the full product.
          result_d = {acc_step[DATA_W-1:0], mq_step};
          error_d  = 1'b0;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (result_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      cmd_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cmd_q    <= cmd_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  // Handshake and status outputs decode directly from the state register.
  always_comb begin
    start_ready  = (state_q == StIdle);
    busy         = (state_q != StIdle);
    result_valid = (state_q == StDone);
    result       = result_q;
    error        = error_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and randomized checks of alu_sequencer against an arithmetic model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] inputA = '0;
  logic [15:0] inputB = '0;
  logic [3:0]  command = '0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] result;
  logic        error;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_sequencer #(
    .DATA_W (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inputA       (inputA),
    .inputB       (inputB),
    .command      (command),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .result       (result),
    .error        (error),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic from the command definitions.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] c,
                       output logic [31:0] r, output logic e, output int lat);
    int sa;
    int sb;
    int s;
    logic [15:0] lo;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (c == 4'b0001 || c == 4'b0101) begin
      s   = (c == 4'b0001) ? sa + sb : sa - sb;
      e   = (s > 32767) || (s < -32768);
      lo  = s[15:0];
      r   = {{16{lo[15]}}, lo};
      lat = 1;
    end else if (c == 4'b1000) begin
      s   = sa * sb;
      r   = s;
      e   = 1'b0;
      lat = 16;
    end else begin
      r   = '0;
      e   = 1'b1;
      lat = 1;
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] c,
                        input int hold, input string tag);
    logic [31:0] exp_r;
    logic        exp_e;
    int          exp_lat;
    int          lat;
    model(a, b, c, exp_r, exp_e, exp_lat);
    @(negedge clk);
    inputA      = a;
    inputB      = b;
    command     = c;
    start_valid = 1'b1;
    check({tag, ".start_ready"}, 32'(start_ready), 32'd1);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    // Scramble inputs after accept: the DUT must use the captured copies.
    inputA  = 16'($urandom);
    inputB  = 16'($urandom);
    command = 4'($urandom);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!result_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".result"}, result, exp_r);
    check({tag, ".error"}, 32'(error), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start_valid = 1'b1;
      inputA      = 16'($urandom);
      command     = 4'b0001;
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, 32'(result_valid), 32'd1);
      check({tag, ".hold_result"}, result, exp_r);
      check({tag, ".hold_error"}, 32'(error), 32'(exp_e));
      check({tag, ".hold_ready"}, 32'(start_ready), 32'd0);
    end
    @(negedge clk);
    start_valid  = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check({tag, ".drained_valid"}, 32'(result_valid), 32'd0);
    check({tag, ".drained_idle"}, 32'(start_ready), 32'd1);
    check({tag, ".kept_result"}, result, exp_r);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [3:0]  rc;
    bit          seen;

    // Reset state
    #12;
    check("reset.result", result, 32'd0);
    check("reset.error", 32'(error), 32'd0);
    check("reset.valid", 32'(result_valid), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.start_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // result_ready while idle must be ignored
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check("idle_ready.valid", 32'(result_valid), 32'd0);

    // Directed cases
    run_op(16'd6, 16'd1, 4'b0001, 0, "add_6_1");
    run_op(16'd6, 16'd1, 4'b0101, 0, "sub_6_1");
    run_op(16'd1, 16'd6, 4'b0101, 0, "sub_1_6");
    run_op(16'h7FFF, 16'h0001, 4'b0001, 0, "add_ovf");
    run_op(16'h8000, 16'h0001, 4'b0101, 0, "sub_ovf");
    run_op(16'hFFFD, 16'd5, 4'b1000, 0, "mul_m3_5");
    run_op(16'h8000, 16'h8000, 4'b1000, 0, "mul_min_min");
    run_op(16'h1234, 16'h4321, 4'b0011, 5, "illegal_hold");
    run_op(16'h7FFF, 16'h7FFF, 4'b1000, 2, "mul_max_max");
    run_op(16'h0000, 16'h8000, 4'b0101, 0, "sub_0_min");

    // Reset in the middle of a multiply
    @(negedge clk);
    inputA      = 16'hFFFD;
    inputB      = 16'd5;
    command     = 4'b1000;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset.busy", 32'(busy), 32'd0);
    check("midreset.start_ready", 32'(start_ready), 32'd1);
    check("midreset.valid", 32'(result_valid), 32'd0);
    check("midreset.result", result, 32'd0);
    check("midreset.error", 32'(error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (result_valid) seen = 1'b1;
    end
    check("midreset.no_valid", 32'(seen), 32'd0);
    run_op(16'd100, 16'hFFCE, 4'b0001, 0, "post_reset_add");

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rc = 4'b0001;
        1:       rc = 4'b0101;
        2:       rc = 4'b1000;
        default: rc = 4'($urandom);
      endcase
      run_op(ra, rb, rc, int'($urandom_range(0, 2)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
